// File: rtl/tdm_mux_n_pkg.sv
// tdm_mux_n_pkg: definitions shared by the TDM multiplexer, its lane FIFO
// and the matching demultiplexer.
//   MODE_FIXED / MODE_RR : values of the SKIP_IDLE parameter
//   clog2()              : ceiling log2 usable in parameter expressions
//   lane_lsb()           : low bit of lane 'lane' in a packed lane bus
package tdm_mux_n_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/tdm_mux_n_lane_fifo.sv
// lane_fifo: synchronous FIFO, one per input lane of tdm_mux_n.
//   clk, rst    : clock, asynchronous active-high reset (empties the FIFO)
//   push, din   : write din when push is high and the FIFO is not full
//   pop         : drop the head word when pop is high and the FIFO is not empty
//   head        : word at the read pointer (valid while !empty)
//   count       : number of stored words, 0..FIFO_DEPTH
//   full, empty : status decoded from count
// A push and a pop in the same cycle both take effect and count is unchanged.
module lane_fifo
  import tdm_mux_n_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int PTR_W     = (clog2(FIFO_DEPTH) < 1) ? 1 : clog2(FIFO_DEPTH),
  localparam int CNT_W     = clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; stale contents are never visible while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/tdm_mux_n.sv
// tdm_mux_n: N-lane time-division word multiplexer with per-lane FIFOs.
//   clk8f     : single clock, all state on its rising edge
//   reset     : asynchronous active-high reset, clears everything
//   data_in   : lane i word at bits [i*DATA_W +: DATA_W]
//   valid_in  : per-lane push strobe
//   ready_in  : per-lane FIFO can accept a word
//   data_out  : registered output word
//   valid_out : registered, data_out carries a real word
//   lane_out  : registered source-lane tag
//   overflow  : sticky per-lane flag, a push was dropped
// Input handshake: a word on lane i is accepted on a rising edge where
// valid_in[i] && ready_in[i]; valid_in[i] with !ready_in[i] drops the word
// and sets overflow[i]. ready_in depends only on registered count and
// reset, never on a same-cycle pop. The output side has no back-pressure:
// every cycle with valid_out = 1 carries one word.
// SKIP_IDLE = MODE_FIXED: a slot counter visits every lane once per LANES
// cycles whether or not it has data. SKIP_IDLE = MODE_RR: the first
// non-empty lane at or after the grant pointer is served every cycle.
module tdm_mux_n
  import tdm_mux_n_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LANES      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int SKIP_IDLE  = 0,
  localparam int LANE_W    = (clog2(LANES) < 1) ? 1 : clog2(LANES),
  localparam int CNT_W     = clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk8f,
  input  logic                    reset,
  input  logic [LANES*DATA_W-1:0] data_in,
  input  logic [LANES-1:0]        valid_in,
  output logic [LANES-1:0]        ready_in,
  output logic [DATA_W-1:0]       data_out,
  output logic                    valid_out,
  output logic [LANE_W-1:0]       lane_out,
  output logic [LANES-1:0]        overflow
);

  logic [DATA_W-1:0] head  [LANES];
  logic [CNT_W-1:0]  count [LANES];
  logic [LANES-1:0]  full;
  logic [LANES-1:0]  empty;
  logic [LANES-1:0]  pop;

  logic [LANE_W-1:0] slot;
  logic [LANE_W-1:0] ptr;
  logic [LANE_W-1:0] sel;
  logic              grant;
  int                idx;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign ready_in[i] = !reset && (count[i] < CNT_W'(FIFO_DEPTH));

    lane_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk8f),
      .rst   (reset),
      .push  (valid_in[i] && ready_in[i]),
      .pop   (pop[i]),
      .din   (data_in[lane_lsb(i, DATA_W) +: DATA_W]),
      .head  (head[i]),
      .count (count[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  // Lane selection. The round-robin search walks from the farthest offset
  // back to offset 0 so the nearest non-empty lane is the one left in sel.
  always_comb begin
    sel   = '0;
    grant = 1'b0;
    idx   = 0;
    if (SKIP_IDLE == MODE_FIXED) begin
      sel   = slot;
      grant = !empty[slot];
    end else begin
      for (int k = LANES - 1; k >= 0; k--) begin
        idx = int'(ptr) + k;
        if (idx >= LANES) idx = idx - LANES;
        if (!empty[idx]) begin
          grant = 1'b1;
          sel   = LANE_W'(idx);
        end
      end
    end
    pop = '0;
    if (grant) pop[sel] = 1'b1;
  end

  always_ff @(posedge clk8f or posedge reset) begin
    if (reset) begin
      slot      <= '0;
      ptr       <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      lane_out  <= '0;
      overflow  <= '0;
    end else begin
      // full is equivalent to !ready_in outside reset.
      overflow  <= overflow | (valid_in & full);
      slot      <= (slot == LANE_W'(LANES - 1)) ? '0 : slot + 1'b1;
      valid_out <= grant;
      if (grant) begin
        data_out <= head[sel];
        lane_out <= sel;
        if (SKIP_IDLE != MODE_FIXED)
          ptr <= (sel == LANE_W'(LANES - 1)) ? '0 : sel + 1'b1;
      end else if (SKIP_IDLE == MODE_FIXED) begin
        // Empty slot still reports which lane owned it; data_out holds.
        lane_out <= slot;
      end
    end
  end

endmodule

// File: tb/tb_tdm_mux_n.sv
// tb_tdm_mux_n: directed bench for tdm_mux_n, one fixed-slot instance and
// one round-robin instance (LANES = 4, FIFO_DEPTH = 4, DATA_W = 8).
module tb_tdm_mux_n;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic [31:0] fix_data = '0;
  logic [3:0]  fix_valid = '0;
  logic [3:0]  fix_ready;
  logic [7:0]  fix_data_out;
  logic        fix_valid_out;
  logic [1:0]  fix_lane_out;
  logic [3:0]  fix_overflow;

  logic [31:0] rr_data = '0;
  logic [3:0]  rr_valid = '0;
  logic [3:0]  rr_ready;
  logic [7:0]  rr_data_out;
  logic        rr_valid_out;
  logic [1:0]  rr_lane_out;
  logic [3:0]  rr_overflow;

  int n_vec = 0;
  int n_err = 0;

  // Expected {lane, word} in output order.
  logic [9:0] fix_q[$];
  logic [9:0] rr_q[$];

  // Fixed-slot reference: m_slot is the slot served at the next edge,
  // m_lane the lane_out expected after the last edge.
  logic [1:0] m_slot;
  logic [1:0] m_lane;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_slot <= 2'd0;
      m_lane <= 2'd0;
    end else begin
      m_lane <= m_slot;
      m_slot <= m_slot + 2'd1;
    end
  end

  tdm_mux_n #(.DATA_W(8), .LANES(4), .FIFO_DEPTH(4), .SKIP_IDLE(0)) u_fix (
    .clk8f     (clk),
    .reset     (reset),
    .data_in   (fix_data),
    .valid_in  (fix_valid),
    .ready_in  (fix_ready),
    .data_out  (fix_data_out),
    .valid_out (fix_valid_out),
    .lane_out  (fix_lane_out),
    .overflow  (fix_overflow)
  );

  tdm_mux_n #(.DATA_W(8), .LANES(4), .FIFO_DEPTH(4), .SKIP_IDLE(1)) u_rr (
    .clk8f     (clk),
    .reset     (reset),
    .data_in   (rr_data),
    .valid_in  (rr_valid),
    .ready_in  (rr_ready),
    .data_out  (rr_data_out),
    .valid_out (rr_valid_out),
    .lane_out  (rr_lane_out),
    .overflow  (rr_overflow)
  );

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever an instance presents a word.
  always @(negedge clk) begin
    logic [9:0] e;
    #2;
    if (!reset) begin
      chk("fix_slot_lane", {30'd0, fix_lane_out}, {30'd0, m_lane});
      if (fix_valid_out) begin
        if (fix_q.size() == 0) begin
          chk("fix_unexpected_word", {22'd0, fix_lane_out, fix_data_out}, 32'hFFFF_FFFF);
        end else begin
          e = fix_q.pop_front();
          chk("fix_word", {22'd0, fix_lane_out, fix_data_out}, {22'd0, e});
        end
      end
      if (rr_valid_out) begin
        if (rr_q.size() == 0) begin
          chk("rr_unexpected_word", {22'd0, rr_lane_out, rr_data_out}, 32'hFFFF_FFFF);
        end else begin
          e = rr_q.pop_front();
          chk("rr_word", {22'd0, rr_lane_out, rr_data_out}, {22'd0, e});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    fix_valid = '0;
    rr_valid  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((fix_q.size() != 0 || rr_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", fix_q.size() + rr_q.size(), 0);
    fix_q.delete();
    rr_q.delete();
  endtask

  task automatic align_slot0();
    int n;
    n = 0;
    while (m_slot != 2'd0 && n < 8) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic fix_push(input int lane, input logic [7:0] w, input bit expect_out);
    fix_valid[lane]         = 1'b1;
    fix_data[lane*8 +: 8]   = w;
    if (expect_out) fix_q.push_back({2'(lane), w});
  endtask

  task automatic rr_push(input int lane, input logic [7:0] w);
    rr_valid[lane]        = 1'b1;
    rr_data[lane*8 +: 8]  = w;
    rr_q.push_back({2'(lane), w});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_fix_valid", {31'd0, fix_valid_out}, 0);
    chk("rst_fix_data", {24'd0, fix_data_out}, 0);
    chk("rst_fix_lane", {30'd0, fix_lane_out}, 0);
    chk("rst_fix_ovf", {28'd0, fix_overflow}, 0);
    chk("rst_fix_ready", {28'd0, fix_ready}, 0);
    chk("rst_rr_ready", {28'd0, rr_ready}, 0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", {28'd0, fix_ready}, 32'hF);

    // Fixed slot: all lanes push together at a slot-3 edge.
    do_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) fix_push(i, 8'hA0 + 8'(i), 1'b1);
    @(negedge clk);
    fix_valid = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fix_back_to_back", {31'd0, fix_valid_out}, 1);
    end
    wait_drain(8);

    // Reset mid-stream: lane 3 holds 3 words before its slot comes up.
    align_slot0();
    for (int k = 0; k < 3; k++) begin
      fix_push(3, 8'h50 + 8'(k), 1'b0);
      @(negedge clk);
    end
    fix_valid = '0;
    reset     = 1'b1;
    #1;
    chk("midrst_data", {24'd0, fix_data_out}, 0);
    chk("midrst_valid", {31'd0, fix_valid_out}, 0);
    chk("midrst_lane", {30'd0, fix_lane_out}, 0);
    chk("midrst_ready", {28'd0, fix_ready}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("midrst_no_stale", {31'd0, fix_valid_out}, 0);
    end

    // Fixed slot, lane 2 only.
    for (int k = 0; k < 3; k++) begin
      fix_push(2, 8'hC0 + 8'(k), 1'b1);
      @(negedge clk);
    end
    fix_valid = '0;
    wait_drain(20);

    // Overflow and push-while-full-and-popping on lane 0.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      fix_push(0, 8'hE0 + 8'(k), 1'b1);
      @(negedge clk);
    end
    chk("ovf_ready_full", {31'd0, fix_ready[0]}, 0);
    chk("ovf_not_yet", {31'd0, fix_overflow[0]}, 0);
    fix_push(0, 8'hE4, 1'b0);
    @(negedge clk);
    chk("ovf_set", {31'd0, fix_overflow[0]}, 1);
    chk("ovf_ready_after_pop", {31'd0, fix_ready[0]}, 1);
    fix_push(0, 8'hE5, 1'b1);
    @(negedge clk);
    fix_valid = '0;
    chk("ovf_refull", {31'd0, fix_ready[0]}, 0);
    chk("hold_valid", {31'd0, fix_valid_out}, 0);
    chk("hold_data", {24'd0, fix_data_out}, 32'hE0);
    wait_drain(40);
    chk("ovf_sticky", {28'd0, fix_overflow}, 32'h1);
    do_reset();
    chk("ovf_cleared", {28'd0, fix_overflow}, 0);

    // Round robin: lanes 1 and 3 backlogged, strict alternation.
    for (int k = 1; k <= 10; k++) begin
      rr_valid = '0;
      if (k <= 4) begin
        rr_push(1, 8'h10 + 8'(k - 1));
        rr_push(3, 8'h30 + 8'(k - 1));
      end
      @(negedge clk);
      chk("rr_no_idle", {31'd0, rr_valid_out}, (k >= 2 && k <= 9) ? 1 : 0);
    end
    rr_valid = '0;
    wait_drain(4);
    chk("rr_hold_lane", {30'd0, rr_lane_out}, 3);
    chk("rr_hold_data", {24'd0, rr_data_out}, 32'h33);

    // Round robin: lanes 0 and 2 together, then lane 1 found by wrapping.
    rr_push(0, 8'h40);
    rr_push(2, 8'h42);
    @(negedge clk);
    rr_valid = '0;
    wait_drain(6);
    rr_push(1, 8'h41);
    @(negedge clk);
    rr_valid = '0;
    chk("rr_lat_before", {31'd0, rr_valid_out}, 0);
    @(negedge clk);
    chk("rr_lat_one", {31'd0, rr_valid_out}, 1);
    chk("rr_wrap_lane", {30'd0, rr_lane_out}, 1);
    wait_drain(4);
    chk("rr_no_ovf", {28'd0, rr_overflow}, 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule
